mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core. Holds the architectural HI/LO registers.
- Consumes the decoder's start/op pair plus the forwarded rs/rt operands.
- Presents HI/LO for the mfhi/mflo result mux.
- Drives busy so the hazard unit can stall dependent MDU instructions.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high for mult/multu (must be >= 1).
- DIV_CYCLES, 10, number of cycles busy stays high for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request from the EX-stage instruction: op is valid this cycle
- op  input  5  operation code: 1=mult, 2=multu, 3=div, 4=divu, 5=mfhi, 6=mflo, 7=mthi, 8=mtlo, others=no-op
- a  input  32  rs operand, forwarded value
- b  input  32  rt operand, forwarded value
- busy  output  1  an operation is in flight
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: at any edge with reset=1, all of the following clear to 0: hi, lo, busy, counter, pending result. Takes priority over everything. Reset mid-operation aborts the op with no commit.
- States:
  - IDLE (busy=0)
  - MUL (busy=1, counter running)
  - DIV (busy=1, counter running)
- IDLE, start=1, op=mult/multu:
  - At edge E0, capture the 64-bit product of a and b into a pending register. mult is signed, multu unsigned.
  - Load counter = MULT_CYCLES; go to MUL.
- IDLE, start=1, op=div/divu, b != 0:
  - Capture pending quotient and remainder at E0. Quotient is truncated toward zero; remainder takes the sign of the dividend. div is signed, divu unsigned.
  - Load counter = DIV_CYCLES; go to DIV.
- div/divu with b = 0: busy asserts for DIV_CYCLES as normal. At completion hi/lo are left unchanged.
- Signed div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- MUL/DIV counting: counter decrements each edge.
  - At the edge where it would reach 0: commit hi = product[63:32] and lo = product[31:0] (or hi = remainder, lo = quotient); return to IDLE.
  - The commit and busy falling happen on the same edge, so busy is high for exactly N cycles after E0.
- mthi/mtlo with start=1 in IDLE: hi (or lo) <= a at that edge. busy does not assert.
- mfhi/mflo: no state change. The pipeline reads hi/lo directly.
- start=1 while busy=1: ignored entirely; in-flight op unaffected. The stall unit must prevent this; the bench checks the ignore anyway.
- start=1 with no-op code: ignored.
- Outputs are registered. hi/lo change only on commit, mthi/mtlo, or reset.

Test Plan:
- reset=1 for 2 cycles -> hi=0, lo=0, busy=0.
- start, op=1, a=5, b=0xFFFFFFFD -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; unchanged while busy.
- start, op=2, a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- start, op=3, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then op=4, a=7, b=0 -> busy 10 cycles, hi/lo unchanged.
- start op=7, a=0x12345678, then op=8, a=0x9ABCDEF0 -> hi and lo updated one edge each; busy never high.
- op=1 started; second start op=7 on cycle 2 -> ignored. Separately, reset asserted on cycle 3 of a div -> busy=0, hi=lo=0, no later commit.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at start and committed after a fixed busy latency.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_op;
  logic        b_zero;
  logic [63:0] a64, b64, prod;
  logic [32:0] a_ext, b_ext, div_den;
  logic [31:0] quot, rem;

  // Operands are widened by one bit so the signed overflow case
  // 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign b_zero    = (b == 32'd0);
  assign a64       = {{32{signed_op & a[31]}}, a};
  assign b64       = {{32{signed_op & b[31]}}, b};
  assign prod      = a64 * b64;
  assign a_ext     = {signed_op & a[31], a};
  assign b_ext     = {signed_op & b[31], b};
  assign div_den   = b_zero ? 33'd1 : b_ext;
  assign quot      = 32'($signed(a_ext) / $signed(div_den));
  assign rem       = 32'($signed(a_ext) % $signed(div_den));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_vld_d = pend_vld_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d  = prod[63:32];
              pend_lo_d  = prod[31:0];
              pend_vld_d = 1'b1;
              cnt_d      = 32'(MULT_CYCLES);
              state_d    = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d  = rem;
              pend_lo_d  = quot;
              pend_vld_d = !b_zero;
              cnt_d      = 32'(DIV_CYCLES);
              state_d    = ST_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_d    = ST_IDLE;
          pend_vld_d = 1'b0;
          if (pend_vld_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_vld_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_vld_q <= pend_vld_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
